// File: rtl/popcount_axil_pkg.sv
// Shared definitions for the popcount AXI4-Lite front end: register map,
// response codes, FSM state enums and the captured write request payload.
package popcount_axil_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_UNMAP  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [STRB_W-1:0] STRB_FULL = 4'hF;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic [1:0]        sel;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_req_t;

endpackage

// File: rtl/popcount_axil_wr.sv
// Write channel: captures AW and W in any order, performs the register
// action once both are held, and drives the B response and core pulses.
module popcount_axil_wr
  import popcount_axil_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        awsel_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  output logic [DATA_W-1:0] write_data_o,
  output logic              write_valid_o,
  output logic              count_rst_o
);

  wr_state_e         state_q, state_d;
  wr_req_t           req_q, req_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              write_valid_q, write_valid_d;
  logic              count_rst_q, count_rst_d;
  logic              aw_fire, w_fire;

  assign aw_fire = awvalid_i && awready_q;
  assign w_fire  = wvalid_i && wready_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= W_IDLE;
      req_q         <= '0;
      awready_q     <= 1'b1;
      wready_q      <= 1'b1;
      bvalid_q      <= 1'b0;
      bresp_q       <= RESP_OKAY;
      write_data_q  <= '0;
      write_valid_q <= 1'b0;
      count_rst_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      write_data_q  <= write_data_d;
      write_valid_q <= write_valid_d;
      count_rst_q   <= count_rst_d;
    end
  end

  // A channel with READY low in W_IDLE has already been captured into req_q.
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    awready_d     = awready_q;
    wready_d      = wready_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    write_data_d  = write_data_q;
    write_valid_d = 1'b0;
    count_rst_d   = 1'b0;

    case (state_q)
      W_IDLE: begin
        if (aw_fire) begin
          awready_d = 1'b0;
          req_d.sel = awsel_i;
        end
        if (w_fire) begin
          wready_d   = 1'b0;
          req_d.data = wdata_i;
          req_d.strb = wstrb_i;
        end
        if ((aw_fire || !awready_q) && (w_fire || !wready_q)) begin
          state_d  = W_RESP;
          bvalid_d = 1'b1;
          bresp_d  = RESP_SLVERR;
          if (req_d.strb == STRB_FULL) begin
            case (req_d.sel)
              REG_DATA: begin
                write_data_d  = req_d.data;
                write_valid_d = 1'b1;
                bresp_d       = RESP_OKAY;
              end
              REG_COUNT: begin
                count_rst_d = req_d.data[0];
                bresp_d     = RESP_OKAY;
              end
              default: ;
            endcase
          end
        end
      end
      W_RESP: begin
        if (bready_i) begin
          state_d   = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
    endcase
  end

  assign awready_o     = awready_q;
  assign wready_o      = wready_q;
  assign bvalid_o      = bvalid_q;
  assign bresp_o       = bresp_q;
  assign write_data_o  = write_data_q;
  assign write_valid_o = write_valid_q;
  assign count_rst_o   = count_rst_q;

endmodule

// File: rtl/popcount_axil.sv
// AXI4-Lite register front end for a popcount core: forwards data words,
// exposes the running count and busy status, and pulses a count clear.
module popcount_axil
  import popcount_axil_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [DATA_W-1:0] S_AXI_WDATA,
  input  logic [STRB_W-1:0] S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [DATA_W-1:0] S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic [DATA_W-1:0] WRITE_DATA,
  output logic              WRITE_VALID,
  input  logic [DATA_W-1:0] COUNT,
  output logic              COUNT_RST,
  input  logic              COUNT_BUSY
);

  rd_state_e         rstate_q, rstate_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  // Only the word-select bits of either address take part in decoding.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

  popcount_axil_wr u_wr (
    .clk_i         (ACLK),
    .rst_i         (ARESET),
    .awsel_i       (S_AXI_AWADDR[3:2]),
    .awvalid_i     (S_AXI_AWVALID),
    .awready_o     (S_AXI_AWREADY),
    .wdata_i       (S_AXI_WDATA),
    .wstrb_i       (S_AXI_WSTRB),
    .wvalid_i      (S_AXI_WVALID),
    .wready_o      (S_AXI_WREADY),
    .bresp_o       (S_AXI_BRESP),
    .bvalid_o      (S_AXI_BVALID),
    .bready_i      (S_AXI_BREADY),
    .write_data_o  (WRITE_DATA),
    .write_valid_o (WRITE_VALID),
    .count_rst_o   (COUNT_RST)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Read data is snapshotted at the AR handshake and held through any R stall.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (rstate_q)
      R_IDLE: begin
        if (S_AXI_ARVALID) begin
          rstate_d  = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rresp_d   = RESP_OKAY;
          case (S_AXI_ARADDR[3:2])
            REG_DATA:   rdata_d = WRITE_DATA;
            REG_COUNT:  rdata_d = COUNT;
            REG_STATUS: rdata_d = {(DATA_W-2)'(0), WRITE_VALID, COUNT_BUSY};
            default: begin
              rdata_d = '0;
              rresp_d = RESP_SLVERR;
            end
          endcase
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rstate_d  = R_IDLE;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
        end
      end
    endcase
  end

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule
